// File: rtl/rom_scan_sequencer_pkg.sv
// Shared types and constants for the lookup-table scan sequencer and its
// downstream table.
package rom_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } scan_state_t;

    localparam int unsigned ADDR_W_DEF = 2;
    localparam int unsigned DATA_W_DEF = 8;

    // Contents of array_example, one byte per address, address 0 rightmost.
    localparam logic [3:0][7:0] ROM_TABLE = {8'h08, 8'h04, 8'h02, 8'h01};

    function automatic logic [7:0] rom_entry(input logic [1:0] a);
        return ROM_TABLE[a];
    endfunction

endpackage

// File: rtl/rom_scan_sequencer_if.sv
// Valid/ready byte stream carrying the scanned table contents downstream.
interface rom_scan_sequencer_if
    import rom_scan_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/array_example.sv
// Four-entry combinational byte lookup table read by the scan sequencer.
module array_example
    import rom_scan_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);
    assign dout = DATA_W'(rom_entry(2'(addr)));
endmodule

// File: rtl/rom_scan_sequencer.sv
// Walks the lookup table in either direction, streams each byte over a
// valid/ready port and accumulates the OR of all delivered bytes.
module rom_scan_sequencer
    import rom_scan_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 down,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_data,
    rom_scan_sequencer_if.master out_if,
    output logic [DATA_W-1:0]    acc,
    output logic                 busy,
    output logic                 done
);
    scan_state_t       state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              dir, dir_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic              last_q, last_n;
    logic [DATA_W-1:0] acc_q, acc_n;
    logic [ADDR_W-1:0] end_addr;
    logic              hs;

    assign end_addr = dir ? '0 : '1;
    assign hs       = valid_q & out_if.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dir     <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dir     <= dir_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            acc_q   <= acc_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir;
        data_n  = data_q;
        valid_n = valid_q;
        last_n  = last_q;
        acc_n   = acc_q;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    cnt_n   = down ? '1 : '0;
                    dir_n   = down;
                    acc_n   = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    data_n  = rom_data;
                    valid_n = 1'b1;
                    last_n  = (cnt == end_addr);
                    state_n = SEND;
                end
            end
            SEND: begin
                // A handshake coinciding with abort still counts the byte.
                if (hs) begin
                    acc_n   = acc_q | data_q;
                    valid_n = 1'b0;
                end
                if (abort) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end else if (hs) begin
                    if (last_q) begin
                        state_n = DONE;
                    end else begin
                        cnt_n   = dir ? cnt - ADDR_W'(1) : cnt + ADDR_W'(1);
                        state_n = LOAD;
                    end
                end
            end
            DONE: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rom_addr         = cnt;
    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign acc              = acc_q;
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);

endmodule

// File: tb/tb_rom_scan_sequencer.sv
// Directed bench for rom_scan_sequencer: cycle table for an up scan plus
// hand-written down-scan, stall, abort, start-while-busy and reset sequences.
module tb_rom_scan_sequencer;
    import rom_scan_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       down;
    logic       abort;
    logic [1:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] acc;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    rom_scan_sequencer_if #(.DATA_W(8)) bus ();

    rom_scan_sequencer #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .down     (down),
        .abort    (abort),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_if   (bus.master),
        .acc      (acc),
        .busy     (busy),
        .done     (done)
    );

    array_example #(.ADDR_W(2), .DATA_W(8)) rom (
        .addr (rom_addr),
        .dout (rom_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       down;
        logic       abort;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
        logic       exp_busy;
        logic       exp_done;
        logic [1:0] exp_addr;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_scan(input bit dir, input int stall_byte, input int stall_len,
                            input bit pulse_starts, input string tag);
        int         n      = 0;
        int         dones  = 0;
        int         stalled = 0;
        int         cyc    = 0;
        logic [1:0] exp_a;
        start = 1'b1;
        down  = dir;
        abort = 1'b0;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_acc_clr"}, 32'(acc), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h1);
        while (cyc < 80) begin
            exp_a = dir ? 2'(3 - n) : 2'(n);
            bus.out_ready = 1'b1;
            if (stalled > 0 && stalled < stall_len) begin
                chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'h1);
                chk({tag, "_stall_data"}, 32'(bus.out_data), 32'(rom_entry(exp_a)));
                bus.out_ready = 1'b0;
                stalled++;
            end else if (stalled == 0 && stall_len > 0 && bus.out_valid && n == stall_byte) begin
                bus.out_ready = 1'b0;
                stalled = 1;
            end
            start = pulse_starts && busy && (cyc % 2 == 0);
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, "_data"}, 32'(bus.out_data), 32'(rom_entry(exp_a)));
                chk({tag, "_last"}, 32'(bus.out_last), 32'(n == 3));
                chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_a));
                n++;
            end
            if (done) dones++;
            if (!busy) break;
            step();
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_finished"}, 32'(busy), 32'h0);
        chk({tag, "_bytes"}, 32'(n), 32'd4);
        chk({tag, "_dones"}, 32'(dones), 32'd1);
        chk({tag, "_acc"}, 32'(acc), 32'h0F);
    endtask

    initial begin
        // start down abort ready | valid data last busy done addr acc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd1, 8'h01};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 2'd1, 8'h01};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 8'h03};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 2'd2, 8'h03};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd3, 8'h07};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 2'd3, 8'h07};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd3, 8'h0F};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3, 8'h0F};

        rst_n = 1'b0;
        start = 1'b0;
        down  = 1'b0;
        abort = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_acc", 32'(acc), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            start = vecs[i].start;
            down  = vecs[i].down;
            abort = vecs[i].abort;
            bus.out_ready = vecs[i].ready;
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            chk($sformatf("tbl%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("tbl%0d_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
            if (vecs[i].exp_valid) begin
                chk($sformatf("tbl%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
                chk($sformatf("tbl%0d_last", i), 32'(bus.out_last), 32'(vecs[i].exp_last));
            end
            step();
        end
        start = 1'b0;

        run_scan(1'b1, -1, 0, 1'b0, "down");
        run_scan(1'b0, 1, 5, 1'b0, "stall");

        // start together with abort in IDLE must be ignored
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'h0);

        // abort on the first handshake of an up scan
        begin
            int k = 0;
            start = 1'b1;
            down  = 1'b0;
            bus.out_ready = 1'b1;
            step();
            start = 1'b0;
            while (!bus.out_valid && k < 10) begin
                step();
                k++;
            end
            chk("abort_reach_send", 32'(bus.out_valid), 32'h1);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'h0);
            chk("abort_valid", 32'(bus.out_valid), 32'h0);
            chk("abort_done", 32'(done), 32'h0);
            chk("abort_acc", 32'(acc), 32'h01);
            for (int j = 0; j < 3; j++) begin
                step();
                chk("abort_no_done", 32'(done), 32'h0);
            end
            chk("abort_acc_hold", 32'(acc), 32'h01);
        end

        run_scan(1'b0, -1, 0, 1'b1, "pulses");
        run_scan(1'b0, -1, 0, 1'b0, "rescan");

        // reset in the middle of the second SEND of a down scan
        begin
            int k = 0;
            start = 1'b1;
            down  = 1'b1;
            bus.out_ready = 1'b1;
            step();
            start = 1'b0;
            while (!(bus.out_valid && acc != 8'h00) && k < 20) begin
                step();
                k++;
            end
            chk("rst_mid_reach", 32'(bus.out_valid), 32'h1);
            bus.out_ready = 1'b0;
            rst_n = 1'b0;
            step();
            chk("rst_mid_addr", 32'(rom_addr), 32'h0);
            chk("rst_mid_data", 32'(bus.out_data), 32'h0);
            chk("rst_mid_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_mid_last", 32'(bus.out_last), 32'h0);
            chk("rst_mid_acc", 32'(acc), 32'h0);
            chk("rst_mid_busy", 32'(busy), 32'h0);
            chk("rst_mid_done", 32'(done), 32'h0);
            rst_n = 1'b1;
            bus.out_ready = 1'b1;
            for (int j = 0; j < 3; j++) begin
                step();
                chk("rst_idle_busy", 32'(busy), 32'h0);
                chk("rst_idle_valid", 32'(bus.out_valid), 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
